// File: rtl/mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mult_product_accumulator
// Purpose  : Sums groups of ACC_LEN multiplier products into a widened
//            accumulator and presents each group on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module mult_product_accumulator #(
  parameter int WIDTH1  = 8,
  parameter int WIDTH2  = 8,
  parameter int ACC_LEN = 16,
  parameter int GUARD   = 4,
  parameter int SAT     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH1+WIDTH2-1:0]         prod_i,
  input  logic                             prod_valid,
  output logic                             prod_ready,
  input  logic                             flush,
  output logic [WIDTH1+WIDTH2+GUARD-1:0]   acc_o,
  output logic                             acc_valid,
  input  logic                             acc_ready,
  output logic                             ovf_o,
  output logic [$clog2(ACC_LEN+1)-1:0]     cnt_o
);

  localparam int PW = WIDTH1 + WIDTH2;
  localparam int AW = PW + GUARD;
  localparam int CW = $clog2(ACC_LEN + 1);

  localparam logic [CW-1:0] c_last_idx = CW'(ACC_LEN - 1);
  localparam logic [AW-1:0] c_acc_max  = '1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_acc,   w_acc_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_ovf,   w_ovf_nxt;
  logic [AW:0]   w_sum;
  logic          w_accept;
  logic          w_complete;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    // One extra bit captures the carry that signals overflow.
    w_sum       = {1'b0, r_acc} + {{(AW+1-PW){1'b0}}, prod_i};

    case (r_state)
      ACCUM: begin
        w_accept = prod_valid;
        if (w_accept) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_sum[AW]) begin
            w_ovf_nxt = 1'b1;
            w_acc_nxt = (SAT != 0) ? c_acc_max : w_sum[AW-1:0];
          end else begin
            w_acc_nxt = w_sum[AW-1:0];
          end
        end
        w_complete = (w_accept && (r_cnt == c_last_idx)) ||
                     (flush && ((r_cnt != '0) || w_accept));
        if (w_complete) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  assign prod_ready = (r_state == ACCUM);
  assign acc_valid  = (r_state == HOLD);
  assign acc_o      = r_acc;
  assign cnt_o      = r_cnt;
  assign ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_product_accumulator
// Purpose  : Directed plus randomized checks of the product accumulator
//            against a group-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_product_accumulator;

  localparam int PW    = 16;
  localparam int A_LEN = 4;
  localparam int A_AW  = 20;
  localparam int A_CW  = 3;
  localparam int B_LEN = 8;
  localparam int B_AW  = 18;
  localparam int B_CW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [PW-1:0]   a_prod  = '0;
  logic            a_valid = 1'b0;
  logic            a_flush = 1'b0;
  logic            a_ready = 1'b0;
  logic            a_prod_ready, a_acc_valid, a_ovf;
  logic [A_AW-1:0] a_acc;
  logic [A_CW-1:0] a_cnt;

  logic [PW-1:0]   b_prod  = '0;
  logic            b_valid = 1'b0;
  logic            b_flush = 1'b0;
  logic            b_ready = 1'b0;
  logic            b_prod_ready, b_acc_valid, b_ovf;
  logic [B_AW-1:0] b_acc;
  logic [B_CW-1:0] b_cnt;
  logic            c_prod_ready, c_acc_valid, c_ovf;
  logic [B_AW-1:0] c_acc;
  logic [B_CW-1:0] c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: true (unbounded) group sum, products in group, holding.
  longint unsigned sa = 0, sb = 0;
  int              na = 0, nb = 0;
  bit              ha = 1'b0, hb = 1'b0;

  always #5 clk = ~clk;

  mult_product_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_LEN(A_LEN), .GUARD(4), .SAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .prod_i(a_prod), .prod_valid(a_valid), .prod_ready(a_prod_ready),
    .flush(a_flush), .acc_o(a_acc), .acc_valid(a_acc_valid), .acc_ready(a_ready),
    .ovf_o(a_ovf), .cnt_o(a_cnt));

  mult_product_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_LEN(B_LEN), .GUARD(2), .SAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .prod_i(b_prod), .prod_valid(b_valid), .prod_ready(b_prod_ready),
    .flush(b_flush), .acc_o(b_acc), .acc_valid(b_acc_valid), .acc_ready(b_ready),
    .ovf_o(b_ovf), .cnt_o(b_cnt));

  mult_product_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_LEN(B_LEN), .GUARD(2), .SAT(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .prod_i(b_prod), .prod_valid(b_valid), .prod_ready(c_prod_ready),
    .flush(b_flush), .acc_o(c_acc), .acc_valid(c_acc_valid), .acc_ready(b_ready),
    .ovf_o(c_ovf), .cnt_o(c_cnt));

  function automatic logic [63:0] exp_acc(input longint unsigned s, input int aw, input bit sat);
    longint unsigned lim;
    lim = 64'd1 << aw;
    if (s < lim) return s;
    return sat ? (lim - 1) : (s % lim);
  endfunction

  function automatic logic [63:0] exp_ovf(input longint unsigned s, input int aw);
    return {63'd0, (s >= (64'd1 << aw))};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    chk("a_prod_ready", {63'd0, a_prod_ready}, {63'd0, !ha});
    chk("a_acc_valid",  {63'd0, a_acc_valid},  {63'd0, ha});
    chk("a_cnt",        64'(a_cnt),            64'(na));
    chk("a_acc",        64'(a_acc),            exp_acc(sa, A_AW, 1'b1));
    chk("a_ovf",        {63'd0, a_ovf},        exp_ovf(sa, A_AW));
  endtask

  task automatic check_b();
    chk("b_prod_ready", {63'd0, b_prod_ready}, {63'd0, !hb});
    chk("b_acc_valid",  {63'd0, b_acc_valid},  {63'd0, hb});
    chk("b_cnt",        64'(b_cnt),            64'(nb));
    chk("b_acc",        64'(b_acc),            exp_acc(sb, B_AW, 1'b1));
    chk("b_ovf",        {63'd0, b_ovf},        exp_ovf(sb, B_AW));
    chk("c_acc_valid",  {63'd0, c_acc_valid},  {63'd0, hb});
    chk("c_cnt",        64'(c_cnt),            64'(nb));
    chk("c_acc",        64'(c_acc),            exp_acc(sb, B_AW, 1'b0));
    chk("c_ovf",        {63'd0, c_ovf},        exp_ovf(sb, B_AW));
  endtask

  task automatic cyc_a(input bit v, input int p, input bit f, input bit r);
    a_valid = v; a_prod = 16'(p); a_flush = f; a_ready = r;
    if (ha) begin
      if (r) begin ha = 1'b0; sa = 0; na = 0; end
    end else begin
      if (v) begin sa += 64'(p); na++; end
      if (na == A_LEN || (f && na > 0)) ha = 1'b1;
    end
    @(posedge clk); #1;
    check_a();
  endtask

  task automatic cyc_b(input bit v, input int p, input bit r);
    b_valid = v; b_prod = 16'(p); b_ready = r;
    if (hb) begin
      if (r) begin hb = 1'b0; sb = 0; nb = 0; end
    end else begin
      if (v) begin sb += 64'(p); nb++; end
      if (nb == B_LEN) hb = 1'b1;
    end
    @(posedge clk); #1;
    check_b();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b1; a_prod = 16'd9; a_flush = 1'b1; a_ready = 1'b0;
    @(posedge clk); #1;
    sa = 0; na = 0; ha = 1'b0; sb = 0; nb = 0; hb = 1'b0;
    rst_n = 1'b1; a_valid = 1'b0; a_flush = 1'b0;
    check_a();
    check_b();
  endtask

  initial begin
    do_reset();

    // Four back-to-back full-scale products
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 65025, 1'b0, 1'b0);
    chk("tp1_acc", 64'(a_acc), 64'd260100);
    chk("tp1_valid", {63'd0, a_acc_valid}, 64'd1);

    // Back-pressure with a pending product of 7
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 7, 1'b0, 1'b0);
    cyc_a(1'b1, 7, 1'b0, 1'b1);
    cyc_a(1'b1, 7, 1'b0, 1'b0);
    chk("bp_cnt", 64'(a_cnt), 64'd1);
    cyc_a(1'b0, 0, 1'b1, 1'b0);
    cyc_a(1'b0, 0, 1'b0, 1'b1);

    // Flush cases
    cyc_a(1'b1, 3, 1'b0, 1'b0);
    cyc_a(1'b1, 5, 1'b0, 1'b0);
    cyc_a(1'b0, 0, 1'b1, 1'b0);
    chk("fl_acc", 64'(a_acc), 64'd8);
    cyc_a(1'b0, 0, 1'b0, 1'b1);
    cyc_a(1'b0, 0, 1'b1, 1'b0);
    chk("fl_empty", {63'd0, a_acc_valid}, 64'd0);
    cyc_a(1'b1, 3, 1'b0, 1'b0);
    cyc_a(1'b1, 4, 1'b1, 1'b0);
    chk("fl_acc2", 64'(a_acc), 64'd7);
    cyc_a(1'b0, 0, 1'b1, 1'b1);

    // Idle gaps between products
    cyc_a(1'b1, 10, 1'b0, 1'b0);
    cyc_a(1'b0, 0,  1'b0, 1'b0);
    cyc_a(1'b1, 20, 1'b0, 1'b0);
    cyc_a(1'b0, 0,  1'b0, 1'b0);
    cyc_a(1'b1, 30, 1'b0, 1'b0);
    cyc_a(1'b0, 0,  1'b0, 1'b0);
    cyc_a(1'b1, 40, 1'b0, 1'b0);
    chk("gap_acc", 64'(a_acc), 64'd100);
    cyc_a(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-group, then a fresh group
    cyc_a(1'b1, 100, 1'b0, 1'b0);
    cyc_a(1'b1, 200, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 1, 1'b0, 1'b0);
    chk("rst_acc", 64'(a_acc), 64'd4);
    cyc_a(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic on the non-overflowing configuration
    for (int i = 0; i < 300; i++)
      cyc_a($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    cyc_a(1'b0, 0, 1'b1, 1'b0);
    cyc_a(1'b0, 0, 1'b0, 1'b1);

    // Narrow-guard overflow: saturating and wrapping instances
    for (int i = 0; i < 8; i++) cyc_b(1'b1, 65025, 1'b0);
    chk("sat_acc", 64'(b_acc), 64'd262143);
    chk("sat_ovf", {63'd0, b_ovf}, 64'd1);
    chk("wrap_acc", 64'(c_acc), 64'd258056);
    chk("wrap_ovf", {63'd0, c_ovf}, 64'd1);
    cyc_b(1'b0, 0, 1'b1);

    for (int i = 0; i < 300; i++)
      cyc_b($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
            $urandom_range(0, 2) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
